// File: rtl/ship_bullet_ctrl.sv
// ship_bullet_ctrl
//   Per-frame motion controller for the player ship and its single bullet.
//   The ship moves horizontally from the buttons and is clamped between the
//   side walls. The bullet is launched from the ship, flies upward, retires
//   at the top wall and is followed by a re-fire cooldown. All state advances
//   only on refr_tick, and every output is a registered value.
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   refr_tick    in   1   one-cycle pulse once per frame
//   btn_left     in   1   move left (level)
//   btn_right    in   1   move right (level)
//   btn_fire     in   1   fire request (level)
//   ship_x       out 11   ship left edge column
//   bull_x       out 11   bullet left edge column
//   bull_y       out 11   bullet top row
//   bull_active  out  1   bullet in flight
//   shots        out  8   launch counter, wraps 255 -> 0
module ship_bullet_ctrl #(
  parameter int unsigned SHIP_X_INIT = 315,
  parameter int unsigned SHIP_W      = 11,
  parameter int unsigned SHIP_T      = 465,
  parameter int unsigned SHIP_V      = 3,
  parameter int unsigned LWALL_R     = 2,
  parameter int unsigned RWALL_L     = 637,
  parameter int unsigned TWALL_R     = 2,
  parameter int unsigned BULL_OFS    = 3,
  parameter int unsigned BULL_H      = 5,
  parameter int unsigned BULL_V      = 4,
  parameter int unsigned COOLDOWN    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refr_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  output logic [10:0] ship_x,
  output logic [10:0] bull_x,
  output logic [10:0] bull_y,
  output logic        bull_active,
  output logic [7:0]  shots
);

  localparam int unsigned CD_W = $clog2(COOLDOWN + 1);

  localparam logic [10:0] X_INIT   = 11'(SHIP_X_INIT);
  localparam logic [10:0] X_MIN    = 11'(LWALL_R + 1);
  localparam logic [10:0] X_MAX    = 11'(RWALL_L - SHIP_W);
  localparam logic [10:0] STEP     = 11'(SHIP_V);
  localparam logic [10:0] OFS      = 11'(BULL_OFS);
  localparam logic [10:0] LAUNCH_Y = 11'(SHIP_T - BULL_H);
  localparam logic [10:0] BSTEP    = 11'(BULL_V);
  // Below this row another full step would enter the top wall.
  localparam logic [10:0] RETIRE_Y = 11'(TWALL_R + 1 + BULL_V);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  typedef enum logic {IDLE, FLY} state_t;

  state_t          state_q, state_d;
  logic [10:0]     ship_x_q, ship_x_d;
  logic [10:0]     bull_x_q, bull_x_d;
  logic [10:0]     bull_y_q, bull_y_d;
  logic [7:0]      shots_q, shots_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            armed_q, armed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ship_x_q <= X_INIT;
      bull_x_q <= X_INIT + OFS;
      bull_y_q <= LAUNCH_Y;
      shots_q  <= '0;
      cd_q     <= '0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ship_x_q <= ship_x_d;
      bull_x_q <= bull_x_d;
      bull_y_q <= bull_y_d;
      shots_q  <= shots_d;
      cd_q     <= cd_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ship_x_d = ship_x_q;
    bull_x_d = bull_x_q;
    bull_y_d = bull_y_q;
    shots_d  = shots_q;
    cd_d     = cd_q;
    armed_d  = armed_q;

    if (refr_tick) begin
      // Clamp is tested before subtracting/adding so the 11-bit math never wraps.
      if (btn_left && !btn_right) begin
        ship_x_d = (ship_x_q < X_MIN + STEP) ? X_MIN : ship_x_q - STEP;
      end else if (btn_right && !btn_left) begin
        ship_x_d = (ship_x_q + STEP > X_MAX) ? X_MAX : ship_x_q + STEP;
      end

      if (!btn_fire) armed_d = 1'b1;

      unique case (state_q)
        IDLE: begin
          if (btn_fire && armed_q && cd_q == '0) begin
            state_d  = FLY;
            // Launch uses the ship position from before this tick's move.
            bull_x_d = ship_x_q + OFS;
            bull_y_d = LAUNCH_Y;
            shots_d  = shots_q + 8'd1;
            armed_d  = 1'b0;
          end else if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
          end
        end
        FLY: begin
          if (bull_y_q < RETIRE_Y) begin
            state_d = IDLE;
            cd_d    = CD_LOAD;
          end else begin
            bull_y_d = bull_y_q - BSTEP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ship_x      = ship_x_q;
  assign bull_x      = bull_x_q;
  assign bull_y      = bull_y_q;
  assign bull_active = (state_q == FLY);
  assign shots       = shots_q;

endmodule
